// File: rtl/gray_counter_controller_pkg.sv
// Shared state encodings and constant helpers for the gray counter controller.
package gray_counter_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Last gray code before a wrap to zero: only the MSB set.
  function automatic logic [31:0] gray_wrap_last(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/gray_counter_controller_step_checker.sv
// gray_step_checker: watches the counter's gray output for wraps and, with
// GRAY_STEP_CHECK_EN defined, for steps that change more than one bit.
module gray_step_checker
  import gray_counter_controller_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cnt_enable,
  input  logic [CNT_W-1:0] gray_code,
  output logic             wrap_hit,
  output logic             step_bad
);

  localparam logic [CNT_W-1:0] WRAP_LAST = CNT_W'(gray_wrap_last(CNT_W));

  logic [CNT_W-1:0] gray_prev_q;
  logic             en_q;

  // The counter moves on the edge after an enabled cycle, so compare against
  // the previous sample only when the enable was high one cycle earlier.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gray_prev_q <= '0;
      en_q        <= 1'b0;
    end else begin
      gray_prev_q <= gray_code;
      en_q        <= cnt_enable;
    end
  end

  assign wrap_hit = en_q && (gray_prev_q == WRAP_LAST) && (gray_code == '0);

`ifdef GRAY_STEP_CHECK_EN
  assign step_bad = en_q && ($countones(gray_prev_q ^ gray_code) != 1);
`else
  assign step_bad = 1'b0;
`endif

endmodule

// File: rtl/gray_counter_controller.sv
// gray_counter_controller: runs the shared gray counter for cmd_len cycles per command.
// Define GRAY_STEP_CHECK_EN to enable the sticky illegal-step flag gray_err.
module gray_counter_controller
  import gray_counter_controller_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int LEN_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_clear,
  input  logic              abort,
  input  logic [CNT_W-1:0]  gray_code,
  output logic              cnt_enable,
  output logic              cnt_clear,
  output logic              done,
  output logic              aborted,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              gray_err
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              gray_err_q, gray_err_d;
  logic              aborted_q, aborted_d;
  logic              accept;
  logic              wrap_hit;
  logic              step_bad;

  gray_step_checker #(.CNT_W(CNT_W)) u_checker (
    .clock      (clock),
    .reset_n    (reset_n),
    .cnt_enable (cnt_enable),
    .gray_code  (gray_code),
    .wrap_hit   (wrap_hit),
    .step_bad   (step_bad)
  );

  assign accept = (state_q == ST_IDLE) && cmd_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      wrap_count_q <= '0;
      gray_err_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      wrap_count_q <= wrap_count_d;
      gray_err_q   <= gray_err_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    aborted_d   = aborted_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_len;
          aborted_d   = 1'b0;
          if (cmd_clear)          state_d = ST_CLEAR;
          else if (cmd_len != '0) state_d = ST_RUN;
          else                    state_d = ST_DONE;
        end
      end
      ST_CLEAR: state_d = (remaining_q != '0) ? ST_RUN : ST_DONE;
      ST_RUN: begin
        remaining_d = remaining_q - LEN_W'(1);
        // An abort on the final cycle still reports aborted.
        if (abort) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (remaining_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wrap_count_d = wrap_count_q;
    gray_err_d   = gray_err_q;
    if (accept) begin
      gray_err_d = 1'b0;
      if (cmd_clear) wrap_count_d = '0;
    end else begin
      if (wrap_hit && (wrap_count_q != '1)) wrap_count_d = wrap_count_q + WRAP_W'(1);
      if (step_bad) gray_err_d = 1'b1;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign cnt_clear  = (state_q == ST_CLEAR);
  assign cnt_enable = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign aborted    = (state_q == ST_DONE) && aborted_q;
  assign wrap_count = wrap_count_q;
  assign gray_err   = gray_err_q;

endmodule

// File: tb/tb_gray_counter_controller.sv
// Bench for gray_counter_controller driving a behavioural 4-bit gray counter.
// Honours GRAY_STEP_CHECK_EN for the expected gray_err value.
module tb_gray_counter_controller;

  typedef struct {
    logic [7:0] len;
    logic       clear;
    int         abortAt;
    int         expEn;
    int         expClr;
    logic       expAborted;
    logic [3:0] expGray;
    int         expWrap;
    logic       expErr;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = '0;
  logic       cmd_clear = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] gray_code;
  logic       cnt_enable, cnt_clear, done, aborted, gray_err;
  logic [7:0] wrap_count;

  logic [3:0] binQ = '0;
  logic       forceArmed = 1'b0;
  int         passCount = 0;
  int         checkCount = 0;
  int         enCnt = 0;
  int         clrCnt = 0;
  vec_t       expQ[$];
  vec_t       vecs[9];

  gray_counter_controller #(.CNT_W(4), .LEN_W(8), .WRAP_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_clear  (cmd_clear),
    .abort      (abort),
    .gray_code  (gray_code),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .done       (done),
    .aborted    (aborted),
    .wrap_count (wrap_count),
    .gray_err   (gray_err)
  );

  always #5 clock = ~clock;

  // Controlled counter; forceArmed corrupts the code seen at count 2 (0011 -> 0010).
  always @(posedge clock) begin
    if (cnt_clear)       binQ <= '0;
    else if (cnt_enable) binQ <= binQ + 4'd1;
  end
  assign gray_code = (forceArmed && binQ == 4'd2) ? 4'b0010 : (binQ ^ (binQ >> 1));

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: counts enables/clears and compares each done pulse.
  always @(negedge clock) begin
    if (!reset_n) begin
      enCnt  = 0;
      clrCnt = 0;
    end else begin
      if (cnt_enable) enCnt++;
      if (cnt_clear)  clrCnt++;
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          vec_t e;
          e = expQ.pop_front();
          checkOutput("enable_cycles", enCnt, e.expEn);
          checkOutput("clear_cycles", clrCnt, e.expClr);
          checkOutput("aborted", int'(aborted), int'(e.expAborted));
          checkOutput("gray_final", int'(gray_code), int'(e.expGray));
          checkOutput("gray_err_done", int'(gray_err), int'(e.expErr));
        end
        enCnt  = 0;
        clrCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int cycles;
    int runIdx;
    checkOutput("ready_before", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_len   = v.len;
    cmd_clear = v.clear;
    expQ.push_back(v);
    tick();
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_clear = 1'b0;
    checkOutput("accept_clr", int'(cnt_clear), int'(v.clear));
    checkOutput("ready_low", int'(cmd_ready), 0);
    cycles = 0;
    runIdx = 0;
    while (!done && cycles < 400) begin
      if (cnt_enable) runIdx++;
      abort = (v.abortAt != 0) && cnt_enable && (runIdx == v.abortAt);
      tick();
      cycles++;
    end
    abort = 1'b0;
    if (!done) begin
      checkOutput("done_timeout", cycles, v.expClr + v.expEn);
      if (expQ.size() != 0) void'(expQ.pop_front());
      return;
    end
    checkOutput("done_latency", cycles, v.expClr + v.expEn);
    tick();
    checkOutput("done_pulse", int'(done), 0);
    checkOutput("ready_back", int'(cmd_ready), 1);
    checkOutput("wrap_count", int'(wrap_count), v.expWrap);
  endtask

  initial begin
    vec_t v;
    logic expErr;
`ifdef GRAY_STEP_CHECK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    vecs[0] = '{8'd5,   1'b1, 0, 5,   1, 1'b0, 4'b0111, 0,  1'b0};
    vecs[1] = '{8'd0,   1'b0, 0, 0,   0, 1'b0, 4'b0111, 0,  1'b0};
    vecs[2] = '{8'd0,   1'b1, 0, 0,   1, 1'b0, 4'b0000, 0,  1'b0};
    vecs[3] = '{8'd1,   1'b0, 0, 1,   0, 1'b0, 4'b0001, 0,  1'b0};
    vecs[4] = '{8'd20,  1'b1, 3, 3,   1, 1'b1, 4'b0010, 0,  1'b0};
    vecs[5] = '{8'd3,   1'b0, 3, 3,   0, 1'b1, 4'b0101, 0,  1'b0};
    vecs[6] = '{8'd20,  1'b1, 0, 20,  1, 1'b0, 4'b0110, 1,  1'b0};
    vecs[7] = '{8'd12,  1'b0, 0, 12,  0, 1'b0, 4'b0000, 2,  1'b0};
    vecs[8] = '{8'd255, 1'b0, 0, 255, 0, 1'b0, 4'b1000, 17, 1'b0};

    tick();
    tick();
    checkOutput("rst_ready", int'(cmd_ready), 1);
    checkOutput("rst_enable", int'(cnt_enable), 0);
    checkOutput("rst_clear", int'(cnt_clear), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_aborted", int'(aborted), 0);
    checkOutput("rst_wrap", int'(wrap_count), 0);
    checkOutput("rst_err", int'(gray_err), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Drive wrap_count into saturation: each 240-cycle run from 15 wraps 15 times.
    for (int i = 0; i < 17; i++) begin
      v = '{8'd240, 1'b0, 0, 240, 0, 1'b0, 4'b1000, 0, 1'b0};
      v.expWrap = (17 + 15 * (i + 1) > 255) ? 255 : 17 + 15 * (i + 1);
      applyStimulus(v);
    end

    // Reset in the middle of a run returns everything to reset values at once.
    cmd_valid = 1'b1;
    cmd_len   = 8'd20;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = '0;
    tick();
    tick();
    checkOutput("mid_run_enable", int'(cnt_enable), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_ready", int'(cmd_ready), 1);
    checkOutput("async_rst_enable", int'(cnt_enable), 0);
    checkOutput("async_rst_done", int'(done), 0);
    checkOutput("async_rst_wrap", int'(wrap_count), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", int'(cmd_ready), 1);
    checkOutput("post_rst_done", int'(done), 0);

    // Corrupted gray step during a run sets the sticky error flag.
    forceArmed = 1'b1;
    v = '{8'd5, 1'b1, 0, 5, 1, 1'b0, 4'b0111, 0, 1'b0};
    v.expErr = expErr;
    applyStimulus(v);
    forceArmed = 1'b0;
    tick();
    checkOutput("gray_err_sticky", int'(gray_err), int'(expErr));
    v = '{8'd0, 1'b0, 0, 0, 0, 1'b0, 4'b0111, 0, 1'b0};
    applyStimulus(v);
    checkOutput("gray_err_cleared", int'(gray_err), 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
